wr_fram_axi_wr: RTL and testbench
=================================

Name: wr_fram_axi_wr

Overview:
- Downstream consumer of the write frame buffer: a dual-port RAM with a 256-bit read side, 256 entries and 1-cycle read latency with no output register.
- Runs in the DDR/AXI clock domain.
- Reads each completed video line out of the buffer's ping-pong halves and writes it to DDR as AXI4 INCR write bursts, advancing a line address through the frame.

Parameters:
- ADDR_W, 28, AXI byte-address width.
- FRAME_BASE, 28'h000_0000, DDR byte address of line 0 of the frame.
- LINE_WORDS, 80, 256-bit words per line. Legal range 1..128.
- BURST_LEN, 16, maximum beats per AXI burst. Legal range 1..16.
- BUF_AW, 8, buffer read-address width. The MSB selects the ping-pong half.

Ports:
- clk  in  1  DDR-domain clock
- rst_n  in  1  synchronous active-low reset
- line_done  in  1  1-cycle pulse: one line fully written into the buffer half owned by the writer (already synchronised into clk)
- frame_start  in  1  1-cycle pulse at start of frame
- buf_rd_addr  out  BUF_AW  buffer read address
- buf_rd_data  in  256  buffer read data, valid 1 cycle after the address
- axi_awaddr  out  ADDR_W  burst start byte address
- axi_awlen  out  8  beats-1
- axi_awvalid  out  1  address valid
- axi_awready  in  1  address ready
- axi_wdata  out  256  write data
- axi_wstrb  out  32  always all-ones
- axi_wvalid  out  1  data valid
- axi_wlast  out  1  last beat of burst
- axi_wready  in  1  data ready
- axi_bvalid  in  1  response valid
- axi_bready  out  1  response ready
- line_pending  out  2  lines waiting or in progress (0..2)
- ovf  out  1  sticky overflow
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - all outputs 0, except axi_wstrb, which is all-ones;
  - state=IDLE, line_addr=FRAME_BASE, rd_half=0, pending=0;
  - skid FIFO empty.
- Reset asserted mid-burst aborts the burst immediately, with no AXI completion. The DDR side is reset together with this block.
- pending:
  - +1 on line_done;
  - -1 when the last B response of a line is accepted;
  - both in the same cycle: unchanged;
  - line_done while pending==2: pending stays 2 and ovf is set to 1 until reset.
- States:
  - IDLE: if pending>0, load beats_left=LINE_WORDS, burst_addr=line_addr, rd_ptr={rd_half, 7'd0}, then go to AW.
  - AW: axi_awvalid=1, axi_awlen=min(beats_left,BURST_LEN)-1. On awvalid&awready, go to WDATA.
    - awaddr/awlen are held stable while waiting.
  - WDATA:
    - Stream exactly awlen+1 beats.
    - axi_wlast=1 on the final beat of the burst.
    - On the final beat handshake, go to BRESP.
  - BRESP: axi_bready=1. On bvalid:
    - beats_left -= burst beats;
    - burst_addr += beats*32;
    - if beats_left>0, go to AW;
    - otherwise line_addr += LINE_WORDS*32, rd_half toggles, pending decrements, go to IDLE.
- Read datapath, 2-entry skid FIFO between the RAM and the W channel:
  - A buffer read issues when (FIFO occupancy + reads in flight) < 2 and reads remain in the current burst.
  - rd_ptr increments per issue.
  - Data is captured 1 cycle after issue.
  - axi_wvalid = FIFO non-empty in WDATA.
  - wready low stalls without dropping or duplicating a word.
  - Reads for a burst may prefetch during AW but never cross into the next burst's beats before its AW is issued.
  - Sustained throughput is 1 beat/clk while wready=1.
- Addresses wrap modulo 2^ADDR_W. No 4 KB boundary handling.
  - FRAME_BASE and LINE_WORDS*32 are 4 KB-aligned in use, or BURST_LEN*32 divides 4096.
- frame_start:
  - in IDLE with pending==0: line_addr=FRAME_BASE in that cycle;
  - otherwise latched and applied when the current line completes (the return to IDLE);
  - rd_half and pending are unaffected.

Optional Feature:
- Macro: WR_FRAM_PINGPONG_EN.
- Defined:
  - adds parameter FRAME_BASE1 (default 28'h080_0000) and output frame_idx (1 bit, reset 0);
  - each applied frame_start toggles frame_idx and loads line_addr with FRAME_BASE1 if the new frame_idx=1, else FRAME_BASE.
- Undefined: no frame_idx port; every frame restarts at FRAME_BASE.

Test Plan:
- Default parameters, one line_done, awready/wready/bvalid always 1:
  - 5 bursts, awaddr 0x000, 0x200, 0x400, 0x600, 0x800, all awlen=15;
  - wdata equals buffer words 0..79 in order;
  - wlast on beats 16, 32, 48, 64, 80;
  - pending returns to 0.
- LINE_WORDS=40:
  - awlen 15, 15, 7;
  - second line_done reads buffer 128..167 at awaddr starting 0x500.
- Random wready, ~50% duty: all 80 words delivered exactly once, in order, no gaps in wlast placement.
- Three line_done pulses with awready held 0: pending=2, ovf=1 sticky; release awready -> two lines complete.
- frame_start mid-line:
  - current line finishes at its address;
  - next line starts at FRAME_BASE;
  - with WR_FRAM_PINGPONG_EN, next line starts at 0x800000 and frame_idx=1.
- rst_n=0 during WDATA: next cycle all valids 0, pending=0, buf_rd_addr=0, line_addr=FRAME_BASE.

Source files
------------

// File: rtl/wr_fram_axi_wr.sv
// Drains completed lines from the ping-pong write frame buffer into DDR as AXI4 INCR write bursts.
// Optional feature macro WR_FRAM_PINGPONG_EN: frames alternate between FRAME_BASE and FRAME_BASE1.
module wr_fram_axi_wr #(
  parameter int                ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] FRAME_BASE  = 28'h000_0000,
`ifdef WR_FRAM_PINGPONG_EN
  parameter logic [ADDR_W-1:0] FRAME_BASE1 = 28'h080_0000,
`endif
  parameter int                LINE_WORDS  = 80,
  parameter int                BURST_LEN   = 16,
  parameter int                BUF_AW      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_done,
  input  logic              frame_start,
  output logic [BUF_AW-1:0] buf_rd_addr,
  input  logic [255:0]      buf_rd_data,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic [7:0]        axi_awlen,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [255:0]      axi_wdata,
  output logic [31:0]       axi_wstrb,
  output logic              axi_wvalid,
  output logic              axi_wlast,
  input  logic              axi_wready,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  output logic [1:0]        line_pending,
  output logic              ovf,
`ifdef WR_FRAM_PINGPONG_EN
  output logic              frame_idx,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_WDATA, S_BRESP} state_t;

  localparam logic [7:0]        LINE_BEATS = 8'(LINE_WORDS);
  localparam logic [7:0]        BURST_MAX  = 8'(BURST_LEN);
  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(LINE_WORDS * 32);

  function automatic logic [7:0] burst_of(input logic [7:0] left);
    return (left > BURST_MAX) ? BURST_MAX : left;
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] line_addr;
  logic [ADDR_W-1:0] restart_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        beats_left;
  logic [7:0]        burst_beats;
  logic [7:0]        rd_left;
  logic [7:0]        w_left;
  logic [7:0]        next_left;
  logic [1:0]        pending;
  logic              rd_half;
  logic              frame_pend;
  logic [BUF_AW-1:0] rd_ptr;
  logic              rd_inflight;
  logic              rd_issue;
  logic              w_fire;
  logic              line_end;
  logic [255:0]      fifo_mem [2];
  logic              fifo_wp;
  logic              fifo_rp;
  logic [1:0]        fifo_cnt;
  logic [1:0]        fifo_fill;

  assign w_fire    = axi_wvalid & axi_wready;
  assign fifo_fill = fifo_cnt + {1'b0, rd_inflight};
  // A beat leaving the skid FIFO this cycle frees a slot, so a read may issue against it (1 beat/clk).
  assign rd_issue  = (state == S_AW || state == S_WDATA) && (rd_left != 8'd0) &&
                     ((fifo_fill != 2'd2) || w_fire);
  assign next_left = beats_left - burst_beats;
  assign next_addr = axi_awaddr + ADDR_W'({burst_beats, 5'd0});
  assign line_end  = (state == S_BRESP) && axi_bvalid && (next_left == 8'd0);

`ifdef WR_FRAM_PINGPONG_EN
  assign restart_addr = frame_idx ? FRAME_BASE : FRAME_BASE1;
`else
  assign restart_addr = FRAME_BASE;
`endif

  assign buf_rd_addr  = rd_ptr;
  assign axi_wvalid   = (state == S_WDATA) && (fifo_cnt != 2'd0);
  assign axi_wlast    = axi_wvalid && (w_left == 8'd1);
  assign axi_wdata    = axi_wvalid ? fifo_mem[fifo_rp] : '0;
  assign axi_wstrb    = '1;
  assign line_pending = pending;
  assign busy         = (state != S_IDLE);

  // NOTE: the skid storage carries no reset; occupancy is tracked by reset counters and wdata is gated.
  always_ff @(posedge clk) begin
    if (rd_inflight) fifo_mem[fifo_wp] <= buf_rd_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      line_addr   <= FRAME_BASE;
      beats_left  <= '0;
      burst_beats <= '0;
      rd_left     <= '0;
      w_left      <= '0;
      pending     <= '0;
      ovf         <= 1'b0;
      rd_half     <= 1'b0;
      frame_pend  <= 1'b0;
      rd_ptr      <= '0;
      rd_inflight <= 1'b0;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_cnt    <= '0;
      axi_awaddr  <= '0;
      axi_awlen   <= '0;
      axi_awvalid <= 1'b0;
      axi_bready  <= 1'b0;
`ifdef WR_FRAM_PINGPONG_EN
      frame_idx   <= 1'b0;
`endif
    end else begin
      if (line_done && !line_end) begin
        if (pending == 2'd2) ovf <= 1'b1;
        else                 pending <= pending + 2'd1;
      end else if (!line_done && line_end) begin
        pending <= pending - 2'd1;
      end

      rd_inflight <= rd_issue;
      if (rd_issue) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_left <= rd_left - 8'd1;
      end
      if (rd_inflight) fifo_wp <= ~fifo_wp;
      if (w_fire)      fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, w_fire};

      if (frame_start) begin
        if (state == S_IDLE && pending == 2'd0) begin
          line_addr <= restart_addr;
`ifdef WR_FRAM_PINGPONG_EN
          frame_idx <= ~frame_idx;
`endif
        end else begin
          frame_pend <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (pending != 2'd0) begin
            beats_left  <= LINE_BEATS;
            burst_beats <= burst_of(LINE_BEATS);
            rd_left     <= burst_of(LINE_BEATS);
            w_left      <= burst_of(LINE_BEATS);
            axi_awaddr  <= line_addr;
            axi_awlen   <= burst_of(LINE_BEATS) - 8'd1;
            axi_awvalid <= 1'b1;
            rd_ptr      <= {rd_half, {(BUF_AW-1){1'b0}}};
            state       <= S_AW;
          end
        end
        S_AW: begin
          if (axi_awready) begin
            axi_awvalid <= 1'b0;
            state       <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (w_fire) begin
            w_left <= w_left - 8'd1;
            if (w_left == 8'd1) begin
              axi_bready <= 1'b1;
              state      <= S_BRESP;
            end
          end
        end
        S_BRESP: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            beats_left <= next_left;
            if (next_left != 8'd0) begin
              burst_beats <= burst_of(next_left);
              rd_left     <= burst_of(next_left);
              w_left      <= burst_of(next_left);
              axi_awaddr  <= next_addr;
              axi_awlen   <= burst_of(next_left) - 8'd1;
              axi_awvalid <= 1'b1;
              state       <= S_AW;
            end else begin
              rd_half <= ~rd_half;
              state   <= S_IDLE;
              // A frame_start seen during the line takes effect only once the line has landed.
              if (frame_pend || frame_start) begin
                line_addr  <= restart_addr;
                frame_pend <= 1'b0;
`ifdef WR_FRAM_PINGPONG_EN
                frame_idx  <= ~frame_idx;
`endif
              end else begin
                line_addr <= line_addr + LINE_BYTES;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wr_fram_axi_wr.sv
// Self-checking bench for wr_fram_axi_wr: instance 0 uses 80-word lines, instance 1 uses 40-word lines.
module tb_wr_fram_axi_wr;

  localparam logic [27:0] FB0 = 28'h000_0000;
`ifdef WR_FRAM_PINGPONG_EN
  localparam logic [27:0] FB1 = 28'h080_0000;
`endif
  localparam int BL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         line_done    [2];
  logic         frame_start  [2];
  logic [7:0]   buf_rd_addr  [2];
  logic [255:0] buf_rd_data  [2];
  logic [27:0]  awaddr       [2];
  logic [7:0]   awlen        [2];
  logic         awvalid      [2];
  logic         awready      [2];
  logic [255:0] wdata        [2];
  logic [31:0]  wstrb        [2];
  logic         wvalid       [2];
  logic         wlast        [2];
  logic         wready       [2];
  logic         bvalid       [2];
  logic         bready       [2];
  logic [1:0]   line_pending [2];
  logic         ovf          [2];
  logic         busy         [2];
`ifdef WR_FRAM_PINGPONG_EN
  logic         frame_idx    [2];
`endif
  logic         w_rand;
  logic         w_rnd;

  logic [255:0] buf_mem [256];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wr_fram_axi_wr #(.LINE_WORDS(g == 0 ? 80 : 40)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .line_done   (line_done[g]),
      .frame_start (frame_start[g]),
      .buf_rd_addr (buf_rd_addr[g]),
      .buf_rd_data (buf_rd_data[g]),
      .axi_awaddr  (awaddr[g]),
      .axi_awlen   (awlen[g]),
      .axi_awvalid (awvalid[g]),
      .axi_awready (awready[g]),
      .axi_wdata   (wdata[g]),
      .axi_wstrb   (wstrb[g]),
      .axi_wvalid  (wvalid[g]),
      .axi_wlast   (wlast[g]),
      .axi_wready  (wready[g]),
      .axi_bvalid  (bvalid[g]),
      .axi_bready  (bready[g]),
      .line_pending(line_pending[g]),
      .ovf         (ovf[g]),
`ifdef WR_FRAM_PINGPONG_EN
      .frame_idx   (frame_idx[g]),
`endif
      .busy        (busy[g])
    );
    assign wready[g] = w_rand ? w_rnd : 1'b1;
    // Frame buffer RAM: one cycle read latency, no output register.
    always @(posedge clk) buf_rd_data[g] <= buf_mem[buf_rd_addr[g]];
  end

  always @(posedge clk) begin
    #1;
    w_rnd = 1'($urandom_range(0, 1));
  end

  // Observed AXI traffic, sampled mid-cycle where valid/ready are stable.
  logic [27:0]  got_aw_addr [$];
  logic [7:0]   got_aw_len  [$];
  logic [255:0] got_w_data  [$];
  logic         got_w_last  [$];
  int           got_b = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int g = 0; g < 2; g++) begin
        if (awvalid[g] && awready[g]) begin
          got_aw_addr.push_back(awaddr[g]);
          got_aw_len.push_back(awlen[g]);
        end
        if (wvalid[g] && wready[g]) begin
          got_w_data.push_back(wdata[g]);
          got_w_last.push_back(wlast[g]);
        end
        if (bvalid[g] && bready[g]) got_b++;
      end
    end
  end

  // Reference model: per-instance next line address and buffer half.
  logic [27:0]  exp_aw_addr [$];
  logic [7:0]   exp_aw_len  [$];
  logic [255:0] exp_w_data  [$];
  logic         exp_w_last  [$];
  logic [27:0]  m_addr [2];
  logic         m_half [2];
  int           b_base;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_line(input int g);
    line_done[g] = 1'b1;
    tick();
    line_done[g] = 1'b0;
  endtask

  task automatic pulse_frame(input int g);
    frame_start[g] = 1'b1;
    tick();
    frame_start[g] = 1'b0;
  endtask

  task automatic expect_line(input int g);
    int lw;
    int sent;
    int n;
    lw   = (g == 0) ? 80 : 40;
    sent = 0;
    while (sent < lw) begin
      n = (lw - sent > BL) ? BL : lw - sent;
      exp_aw_addr.push_back(m_addr[g] + 28'(sent * 32));
      exp_aw_len.push_back(8'(n - 1));
      sent += n;
    end
    for (int w = 0; w < lw; w++) begin
      exp_w_data.push_back(buf_mem[{m_half[g], 7'(w)}]);
      exp_w_last.push_back(((w + 1) % BL == 0) || (w == lw - 1));
    end
    m_addr[g] = m_addr[g] + 28'(lw * 32);
    m_half[g] = ~m_half[g];
  endtask

  task automatic clear_all();
    got_aw_addr.delete(); got_aw_len.delete(); got_w_data.delete(); got_w_last.delete();
    exp_aw_addr.delete(); exp_aw_len.delete(); exp_w_data.delete(); exp_w_last.delete();
    b_base = got_b;
  endtask

  task automatic wait_idle(input int g, input int budget, output int cycles);
    bit done;
    done   = 1'b0;
    cycles = 0;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (line_pending[g] == 2'd0 && !busy[g]) done = 1'b1;
    end
    check("idle_within_budget", 256'(done), 256'(1));
    tick();
  endtask

  task automatic compare_streams(input string tag);
    check({tag, "_aw_count"}, 256'(got_aw_addr.size()), 256'(exp_aw_addr.size()));
    check({tag, "_b_count"}, 256'(got_b - b_base), 256'(exp_aw_addr.size()));
    for (int i = 0; i < exp_aw_addr.size() && i < got_aw_addr.size(); i++) begin
      check($sformatf("%s_aw%0d_addr", tag, i), 256'(got_aw_addr[i]), 256'(exp_aw_addr[i]));
      check($sformatf("%s_aw%0d_len", tag, i), 256'(got_aw_len[i]), 256'(exp_aw_len[i]));
    end
    check({tag, "_w_count"}, 256'(got_w_data.size()), 256'(exp_w_data.size()));
    for (int i = 0; i < exp_w_data.size() && i < got_w_data.size(); i++) begin
      check($sformatf("%s_w%0d_data", tag, i), got_w_data[i], exp_w_data[i]);
      check($sformatf("%s_w%0d_last", tag, i), 256'(got_w_last[i]), 256'(exp_w_last[i]));
    end
    clear_all();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst_n  = 1'b0;
    w_rand = 1'b0;
    b_base = 0;
    for (int g = 0; g < 2; g++) begin
      line_done[g]   = 1'b0;
      frame_start[g] = 1'b0;
      awready[g]     = 1'b1;
      bvalid[g]      = 1'b1;
      m_addr[g]      = FB0;
      m_half[g]      = 1'b0;
    end
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < 8; k++) buf_mem[i][k*32 +: 32] = $urandom();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awvalid", 256'(awvalid[0]), 256'(0));
    check("rst_wvalid", 256'(wvalid[0]), 256'(0));
    check("rst_wlast", 256'(wlast[0]), 256'(0));
    check("rst_bready", 256'(bready[0]), 256'(0));
    check("rst_awaddr", 256'(awaddr[0]), 256'(0));
    check("rst_awlen", 256'(awlen[0]), 256'(0));
    check("rst_wdata", wdata[0], 256'(0));
    check("rst_wstrb", 256'(wstrb[0]), 256'(32'hFFFF_FFFF));
    check("rst_buf_rd_addr", 256'(buf_rd_addr[0]), 256'(0));
    check("rst_pending", 256'(line_pending[0]), 256'(0));
    check("rst_ovf", 256'(ovf[0]), 256'(0));
    check("rst_busy", 256'(busy[0]), 256'(0));
`ifdef WR_FRAM_PINGPONG_EN
    check("rst_frame_idx", 256'(frame_idx[0]), 256'(0));
`endif
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // One full line, all ready: five 16-beat bursts at full rate.
    clear_all();
    expect_line(0);
    pulse_line(0);
    wait_idle(0, 300, cyc);
    compare_streams("t1");
    check("t1_cycles_le_120", 256'(cyc <= 120), 256'(1));
    check("t1_pending_zero", 256'(line_pending[0]), 256'(0));

    // 40-word lines: 15,15,7 bursts; the second line reads the upper half at 0x500.
    expect_line(1);
    expect_line(1);
    pulse_line(1);
    pulse_line(1);
    wait_idle(1, 400, cyc);
    compare_streams("t2");

    // Random wready backpressure.
    w_rand = 1'b1;
    expect_line(0);
    pulse_line(0);
    wait_idle(0, 800, cyc);
    compare_streams("t3");
    w_rand = 1'b0;

    // Overflow: three lines announced while the address channel is blocked.
    awready[0] = 1'b0;
    pulse_line(0);
    pulse_line(0);
    pulse_line(0);
    repeat (5) tick();
    @(negedge clk);
    check("t4_pending_two", 256'(line_pending[0]), 256'(2));
    check("t4_ovf_set", 256'(ovf[0]), 256'(1));
    check("t4_awvalid_held", 256'(awvalid[0]), 256'(1));
    check("t4_awaddr_held", 256'(awaddr[0]), 256'(m_addr[0]));
    check("t4_awlen_held", 256'(awlen[0]), 256'(BL - 1));
    tick();
    expect_line(0);
    expect_line(0);
    awready[0] = 1'b1;
    wait_idle(0, 600, cyc);
    compare_streams("t4");
    @(negedge clk);
    check("t4_ovf_sticky", 256'(ovf[0]), 256'(1));
    tick();

    // frame_start mid-line: current line completes, next line restarts the frame.
    expect_line(0);
    pulse_line(0);
    repeat (20) tick();
    pulse_frame(0);
    wait_idle(0, 300, cyc);
    compare_streams("t5_cur");
`ifdef WR_FRAM_PINGPONG_EN
    m_addr[0] = FB1;
    @(negedge clk);
    check("t5_frame_idx", 256'(frame_idx[0]), 256'(1));
    tick();
`else
    m_addr[0] = FB0;
`endif
    expect_line(0);
    pulse_line(0);
    wait_idle(0, 300, cyc);
    compare_streams("t5_next");

    // Reset while the W channel is streaming.
    pulse_line(0);
    begin
      bit seen;
      int n;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 60) begin
        @(negedge clk);
        n++;
        if (wvalid[0]) seen = 1'b1;
      end
      check("t6_wdata_started", 256'(seen), 256'(1));
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_awvalid", 256'(awvalid[0]), 256'(0));
    check("t6_wvalid", 256'(wvalid[0]), 256'(0));
    check("t6_bready", 256'(bready[0]), 256'(0));
    check("t6_pending", 256'(line_pending[0]), 256'(0));
    check("t6_buf_rd_addr", 256'(buf_rd_addr[0]), 256'(0));
    check("t6_busy", 256'(busy[0]), 256'(0));
    check("t6_ovf_cleared", 256'(ovf[0]), 256'(0));
`ifdef WR_FRAM_PINGPONG_EN
    check("t6_frame_idx", 256'(frame_idx[0]), 256'(0));
`endif
    tick();
    clear_all();
    m_addr[0] = FB0;
    m_half[0] = 1'b0;
    expect_line(0);
    pulse_line(0);
    wait_idle(0, 300, cyc);
    compare_streams("t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
